// File: rtl/fetch_boot_ctrl.sv
// Boot sequencer for the IF stage: packs a loader byte stream into IM words,
// then runs the CPU, selects newPC, and stops when the halt instruction is fetched.
module fetch_boot_ctrl #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] HALT_INS  = 32'hFFFF_FFFF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  input  logic [31:0]       PC,
  input  logic [31:0]       nextPC,
  input  logic [31:0]       Ins,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              jmp,
  input  logic [31:0]       jmp_target,
  output logic [31:0]       newPC,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   word_count,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);

  state_t              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [31:0]         partial_q, partial_d;
  logic                done_q, done_d;
  logic                im_we_q, im_we_d;
  logic [ADDR_W-1:0]   im_waddr_q, im_waddr_d;
  logic [31:0]         im_wdata_q, im_wdata_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                err_q, err_d;
  logic                cpu_en_q, cpu_en_d;

  logic                accept;
  logic                word_done;
  logic                overflow;
  logic [31:0]         merged;
  logic [ADDR_W+1:0]   words_committed;

  // Big-endian lane placement: lane 0 lands in [31:24].
  function automatic logic [31:0] insert_byte(input logic [31:0] base,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] w;
    w = base;
    case (lane)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

  assign ld_ready  = (state_q == S_LOAD) && !done_q;
  assign accept    = ld_valid && ld_ready;
  assign word_done = (lane_q == 2'd3) || ld_last;
  assign merged    = insert_byte((lane_q == 2'd0) ? 32'h0 : partial_q, lane_q, ld_byte);

  // A write in flight this cycle is not yet reflected in word_count_q.
  assign words_committed = {1'b0, word_count_q} + (ADDR_W+2)'(im_we_q);
  assign overflow        = (words_committed == DEPTH_W);

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    partial_d    = partial_q;
    done_d       = done_q;
    im_we_d      = 1'b0;
    im_waddr_d   = im_waddr_q + ADDR_W'(im_we_q);
    im_wdata_d   = im_wdata_q;
    word_count_d = word_count_q + (ADDR_W+1)'(im_we_q);
    err_d        = err_q;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d      = S_LOAD;
          word_count_d = '0;
          im_waddr_d   = '0;
          lane_d       = 2'd0;
          done_d       = 1'b0;
          err_d        = 1'b0;
        end
      end
      S_LOAD: begin
        if (done_q) begin
          state_d = S_RUN;
        end else if (accept) begin
          partial_d = merged;
          lane_d    = lane_q + 2'd1;
          if (word_done) begin
            lane_d = 2'd0;
            if (overflow) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              im_we_d    = 1'b1;
              im_wdata_d = merged;
              done_d     = ld_last;
            end
          end
        end
      end
      S_RUN: begin
        if ((Ins == HALT_INS) && !stall) begin
          state_d = S_HALT;
        end
      end
    endcase

    cpu_en_d = (state_d == S_RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      lane_q       <= 2'd0;
      done_q       <= 1'b0;
      im_we_q      <= 1'b0;
      im_waddr_q   <= '0;
      im_wdata_q   <= '0;
      word_count_q <= '0;
      err_q        <= 1'b0;
      cpu_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      done_q       <= done_d;
      im_we_q      <= im_we_d;
      im_waddr_q   <= im_waddr_d;
      im_wdata_q   <= im_wdata_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
      cpu_en_q     <= cpu_en_d;
    end
  end

  // Partial-word bytes are masked by the lane counter, so no reset needed.
  always_ff @(posedge CLK) begin
    partial_q <= partial_d;
  end

  always_comb begin
    newPC = RESET_VEC;
    if (state_q == S_RUN) begin
      if (stall)         newPC = PC;
      else if (jmp)      newPC = jmp_target;
      else if (br_taken) newPC = br_target;
      else               newPC = nextPC;
    end
  end

  assign im_we      = im_we_q;
  assign im_waddr   = im_waddr_q;
  assign im_wdata   = im_wdata_q;
  assign word_count = word_count_q;
  assign err        = err_q;
  assign cpu_en     = cpu_en_q;
  assign state      = state_q;

endmodule

// File: tb/tb_fetch_boot_ctrl.sv
// Bench for fetch_boot_ctrl: randomized loads and run-phase traffic compared
// against a byte-list / priority-rule reference model.
module tb_fetch_boot_ctrl;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DEPTH     = 4;
  localparam logic [31:0] RESET_VEC = 32'h0000_1000;
  localparam logic [31:0] HALT_INS  = 32'hFFFF_FFFF;

  logic              CLK = 1'b0;
  logic              RST, start, ld_valid, ld_ready, ld_last, im_we;
  logic              stall, br_taken, jmp, cpu_en, err;
  logic [7:0]        ld_byte;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata, PC, nextPC, Ins, br_target, jmp_target, newPC;
  logic [1:0]        state;
  logic [ADDR_W:0]   word_count;

  int nchecks = 0;
  int nerrs   = 0;

  logic [7:0]        ld_q[$];
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];

  always #5 CLK = ~CLK;

  fetch_boot_ctrl #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_VEC(RESET_VEC), .HALT_INS(HALT_INS)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_byte(ld_byte), .ld_last(ld_last),
    .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .PC(PC), .nextPC(nextPC), .Ins(Ins), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
    .newPC(newPC), .cpu_en(cpu_en), .state(state), .word_count(word_count), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (im_we === 1'b1) begin
      wa_q.push_back(im_waddr);
      wd_q.push_back(im_wdata);
    end
  end

  // Word i of the byte list, big-endian, missing trailing bytes read as zero.
  function automatic logic [31:0] exp_word(input int i);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++)
      if (4*i + j < ld_q.size()) w[31-8*j -: 8] = ld_q[4*i + j];
    return w;
  endfunction

  function automatic logic [31:0] exp_pc(input bit running);
    if (!running) return RESET_VEC;
    if (stall)    return PC;
    if (jmp)      return jmp_target;
    if (br_taken) return br_target;
    return nextPC;
  endfunction

  task automatic do_load(input int gap_pct, input int rst_after);
    int n, idx, guard, words, exp_acc, nwr;
    bit hs;
    n = ld_q.size(); idx = 0; guard = 0;
    wa_q.delete(); wd_q.delete();
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK); @(negedge CLK);
    start = 1'b0;
    chk("load_state", 32'(state), 32'd1);
    chk("load_wc", 32'(word_count), 32'd0);
    chk("load_err", 32'(err), 32'd0);
    chk("load_ready", 32'(ld_ready), 32'd1);
    while (idx < n) begin
      ld_valid = ($urandom_range(99) >= gap_pct);
      ld_byte  = ld_q[idx];
      ld_last  = (idx == n - 1);
      hs = ld_valid && ld_ready;
      @(posedge CLK); @(negedge CLK);
      if (hs) idx++;
      guard++;
      if (guard > 500) begin
        chk("load_timeout", idx, n);
        break;
      end
      if (hs && state != 2'd1) break;
      if (rst_after > 0 && idx == rst_after) begin
        RST = 1'b1; ld_valid = 1'b0; ld_last = 1'b0;
        @(posedge CLK); @(negedge CLK);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_we", 32'(im_we), 32'd0);
        chk("rst_waddr", 32'(im_waddr), 32'd0);
        chk("rst_wdata", im_wdata, 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_ready", 32'(ld_ready), 32'd0);
        chk("rst_newpc", newPC, RESET_VEC);
        RST = 1'b0;
        return;
      end
    end
    // Hold a stray byte on the bus: it must not be taken after the load ends.
    ld_valid = 1'b1; ld_byte = 8'h5A; ld_last = 1'b0;
    words = (n + 3) / 4;
    if (words <= int'(DEPTH)) begin
      chk("acc_count", idx, n);
      chk("final_we", 32'(im_we), 32'd1);
      chk("done_ready", 32'(ld_ready), 32'd0);
      chk("done_state", 32'(state), 32'd1);
      @(posedge CLK); @(negedge CLK);
      chk("run_state", 32'(state), 32'd2);
      chk("run_cpu_en", 32'(cpu_en), 32'd1);
      chk("run_wc", 32'(word_count), words);
      chk("run_ready", 32'(ld_ready), 32'd0);
      chk("run_we", 32'(im_we), 32'd0);
      chk("run_err", 32'(err), 32'd0);
      nwr = words;
    end else begin
      exp_acc = (n < 4*int'(DEPTH) + 4) ? n : 4*int'(DEPTH) + 4;
      chk("ovf_acc", idx, exp_acc);
      chk("ovf_state", 32'(state), 32'd0);
      chk("ovf_err", 32'(err), 32'd1);
      chk("ovf_we", 32'(im_we), 32'd0);
      chk("ovf_cpu_en", 32'(cpu_en), 32'd0);
      @(posedge CLK); @(negedge CLK);
      chk("ovf_wc", 32'(word_count), DEPTH);
      chk("ovf_ready", 32'(ld_ready), 32'd0);
      chk("ovf_state2", 32'(state), 32'd0);
      nwr = int'(DEPTH);
    end
    ld_valid = 1'b0;
    chk("wr_count", wa_q.size(), nwr);
    for (int i = 0; i < nwr && i < wa_q.size(); i++) begin
      chk($sformatf("wr_addr%0d", i), 32'(wa_q[i]), i);
      chk($sformatf("wr_data%0d", i), wd_q[i], exp_word(i));
    end
  endtask

  task automatic run_random(input int cycles);
    bit running;
    running = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      PC         = $urandom & 32'hFFFF_FFFC;
      nextPC     = PC + 32'd4;
      stall      = ($urandom_range(3) == 0);
      jmp        = ($urandom_range(2) == 0);
      br_taken   = ($urandom_range(1) == 0);
      jmp_target = $urandom;
      br_target  = $urandom;
      Ins        = ($urandom_range(15) == 0) ? HALT_INS : ($urandom & 32'h7FFF_FFFF);
      #1;
      chk("rn_newpc", newPC, exp_pc(running));
      chk("rn_state", 32'(state), running ? 32'd2 : 32'd3);
      chk("rn_cpu_en", 32'(cpu_en), 32'(running));
      @(posedge CLK);
      if (running && Ins == HALT_INS && !stall) running = 1'b0;
    end
    if (running) begin
      @(negedge CLK);
      Ins = HALT_INS; stall = 1'b0;
      @(posedge CLK); @(negedge CLK);
      chk("rn_force_halt", 32'(state), 32'd3);
    end
    @(negedge CLK);
    Ins = '0; stall = 1'b0; jmp = 1'b0; br_taken = 1'b0;
  endtask

  task automatic pc_case(input string tag, input logic s, input logic j, input logic b,
                         input logic [31:0] exp);
    @(negedge CLK);
    PC = 32'h40; nextPC = 32'h44; jmp_target = 32'h100; br_target = 32'h200;
    stall = s; jmp = j; br_taken = b; Ins = '0;
    #1;
    chk(tag, newPC, exp);
  endtask

  initial begin
    int n;
    RST = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
    PC = '0; nextPC = '0; Ins = '0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    jmp = 1'b0; jmp_target = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_we", 32'(im_we), 32'd0);
    chk("reset_waddr", 32'(im_waddr), 32'd0);
    chk("reset_wdata", im_wdata, 32'd0);
    chk("reset_wc", 32'(word_count), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_cpu_en", 32'(cpu_en), 32'd0);
    chk("reset_ready", 32'(ld_ready), 32'd0);
    RST = 1'b0;
    jmp = 1'b1; jmp_target = 32'h1234; #1;
    chk("idle_newpc", newPC, RESET_VEC);
    jmp = 1'b0;

    ld_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_load(0, 0);
    chk("tp_word0", exp_word(0), 32'h1122_3344);
    chk("tp_word1_dut", (wd_q.size() > 1) ? wd_q[1] : 32'h0, 32'h5566_7788);

    pc_case("pri_stall_jmp", 1'b1, 1'b1, 1'b0, 32'h40);
    pc_case("pri_jmp_br",    1'b0, 1'b1, 1'b1, 32'h100);
    pc_case("pri_br",        1'b0, 1'b0, 1'b1, 32'h200);
    pc_case("pri_none",      1'b0, 1'b0, 1'b0, 32'h44);

    @(negedge CLK);
    stall = 1'b0; jmp = 1'b0; br_taken = 1'b0; start = 1'b1;
    @(posedge CLK); @(negedge CLK);
    start = 1'b0;
    chk("start_in_run", 32'(state), 32'd2);

    Ins = HALT_INS; stall = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("halt_stalled", 32'(state), 32'd2);
    stall = 1'b0; jmp = 1'b1;
    @(posedge CLK); @(negedge CLK);
    #1;
    chk("halt_state", 32'(state), 32'd3);
    chk("halt_cpu_en", 32'(cpu_en), 32'd0);
    chk("halt_newpc", newPC, RESET_VEC);
    Ins = '0; jmp = 1'b0;

    ld_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    do_load(30, 0);
    chk("partial_word1", (wd_q.size() > 1) ? wd_q[1] : 32'h0, 32'hEE00_0000);
    run_random(20);

    ld_q.delete();
    for (int i = 0; i < 17; i++) ld_q.push_back(8'($urandom));
    do_load(10, 0);

    ld_q.delete();
    for (int i = 0; i < 12; i++) ld_q.push_back(8'($urandom));
    do_load(0, 6);
    ld_q.delete();
    for (int i = 0; i < 8; i++) ld_q.push_back(8'($urandom));
    do_load(20, 0);
    run_random(10);

    for (int it = 0; it < 12; it++) begin
      n = int'($urandom_range(22, 1));
      ld_q.delete();
      for (int i = 0; i < n; i++) ld_q.push_back(8'($urandom));
      do_load(int'($urandom_range(50, 0)), 0);
      if ((n + 3) / 4 <= int'(DEPTH)) run_random(int'($urandom_range(30, 5)));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", nchecks);
    $fatal(1);
  end

endmodule
